// File: rtl/memory_access.sv
// Memory-access pipeline stage: LOAD/STORE over a req/ack handshake, upstream stall, 1-cycle writeback.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module memory_access #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DWIDTH-1:0] stored_data_i,
    input  logic [DWIDTH-1:0] stored_instr_i,
    input  logic [DWIDTH-1:0] stored_register_i,
    input  logic [4:0]        rflags_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              wb_en_o,
    output logic [4:0]        wb_addr_o,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic [4:0]        wb_flags_o,
    output logic              mem_error_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_LOAD  = 5'd8;
    localparam logic [4:0] OP_STORE = 5'd9;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        flags_q, flags_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DWIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_flags_q, wb_flags_d;
    logic              stall_c;

    logic [4:0] opcode;
    logic [4:0] rd_in;
    logic       is_mem_op;
    logic       unused_instr_bits;

    assign opcode            = stored_instr_i[31:27];
    assign rd_in             = stored_instr_i[26:22];
    assign is_mem_op         = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign unused_instr_bits = ^stored_instr_i[21:0];

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_error_q, mem_error_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        flags_d     = flags_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_flags_d  = 5'd0;
        stall_c     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        mem_error_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    if (rflags_i[4]) begin
                        wb_flags_d = rflags_i;
                    end else if (is_mem_op) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (opcode == OP_STORE);
                        mem_addr_d  = stored_data_i[AWIDTH-1:0];
                        mem_wdata_d = stored_register_i;
                        rd_d        = rd_in;
                        flags_d     = rflags_i;
                        stall_c     = 1'b1;
                        state_d     = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else if (opcode != OP_NOP) begin
                        wb_en_d    = (rd_in != 5'd0);
                        wb_addr_d  = rd_in;
                        wb_data_d  = stored_data_i;
                        wb_flags_d = rflags_i;
                    end
                end
            end
            S_ACCESS: begin
                stall_c = 1'b1;
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_we_q) begin
                        // Last cycle of a store: let upstream advance so it is not re-issued.
                        stall_c = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        wb_en_d    = (rd_q != 5'd0);
                        wb_addr_d  = rd_q;
                        wb_data_d  = mem_rdata_i;
                        wb_flags_d = flags_q;
                        state_d    = S_WB;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_error_d = 1'b1;
                    stall_c     = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_q        <= 5'd0;
            flags_q     <= 5'd0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= 5'd0;
            wb_data_q   <= '0;
            wb_flags_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_flags_q  <= wb_flags_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end
    assign mem_error_o = mem_error_q;
`else
    assign mem_error_o = 1'b0;
`endif

    // Gate with reset so stall is low while reset is held even if a memory op is presented.
    assign stall_o     = stall_c & ~rst;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wb_en_o     = wb_en_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_flags_o  = wb_flags_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access; the timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_memory_access;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] stored_data, stored_instr, stored_register;
    logic [4:0]    rflags;
    logic          stall, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ack;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_flags;
    logic          mem_error;

    int total = 0;
    int bad   = 0;

    memory_access #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid),
        .stored_data_i(stored_data), .stored_instr_i(stored_instr),
        .stored_register_i(stored_register), .rflags_i(rflags),
        .stall_o(stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .wb_flags_o(wb_flags), .mem_error_o(mem_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'd0};
    endfunction

    task automatic present(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] data,
                           input logic [31:0] regv, input logic [4:0] flags);
        in_valid        = 1'b1;
        stored_instr    = mk_instr(op, rd);
        stored_data     = data;
        stored_register = regv;
        rflags          = flags;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({stall, mem_req, mem_we, wb_en, mem_error} !== 5'b0) begin bad++; $display("FAIL reset_ctrl: got %05b want 00000", {stall, mem_req, mem_we, wb_en, mem_error}); end
        total++; if ({mem_addr, mem_wdata, wb_addr, wb_data, wb_flags} !== '0) begin bad++; $display("FAIL reset_data: got nonzero data outputs"); end
        present(5'd8, 5'd4, 32'h10, 32'h0, 5'd0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", mem_req); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        present(5'd2, 5'd3, 32'h1234, 32'h0, 5'b00011);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0b want 0", stall); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL alu_wb_en: got %0b want 1", wb_en); end
        total++; if (wb_addr !== 5'd3) begin bad++; $display("FAIL alu_wb_addr: got %0d want 3", wb_addr); end
        total++; if (wb_data !== 32'h1234) begin bad++; $display("FAIL alu_wb_data: got %h want 00001234", wb_data); end
        total++; if (wb_flags !== 5'b00011) begin bad++; $display("FAIL alu_wb_flags: got %05b want 00011", wb_flags); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL alu_req: got %0b want 0", mem_req); end
        @(negedge clk);
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL alu_pulse: got %0b want 0", wb_en); end
    endtask

    task automatic do_load(input string nm, input logic [4:0] rd, input logic [15:0] addr,
                           input int ack_cycle, input logic [31:0] rdata);
        present(5'd8, rd, {16'h0, addr}, 32'h0, 5'b00100);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall_issue: got %0b want 1", nm, stall); end
        for (int i = 1; i <= ack_cycle; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++; if ({mem_req, mem_we} !== 2'b10) begin bad++; $display("FAIL %s_req_c%0d: got req/we %02b want 10", nm, i, {mem_req, mem_we}); end
            total++; if (mem_addr !== addr) begin bad++; $display("FAIL %s_addr_c%0d: got %h want %h", nm, i, mem_addr, addr); end
            total++; if ({stall, wb_en} !== 2'b10) begin bad++; $display("FAIL %s_stall_c%0d: got stall/wb %02b want 10", nm, i, {stall, wb_en}); end
            if (i == ack_cycle) begin mem_ack = 1'b1; mem_rdata = rdata; end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s_req_drop: got %0b want 0", nm, mem_req); end
        total++; if (wb_en !== (rd != 5'd0)) begin bad++; $display("FAIL %s_wb_en: got %0b want %0b", nm, wb_en, rd != 5'd0); end
        total++; if (wb_data !== rdata) begin bad++; $display("FAIL %s_wb_data: got %h want %h", nm, wb_data, rdata); end
        total++; if ({wb_addr, wb_flags} !== {rd, 5'b00100}) begin bad++; $display("FAIL %s_wb_addr_flags: got %0d/%05b want %0d/00100", nm, wb_addr, wb_flags, rd); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s_stall_wb: got %0b want 0", nm, stall); end
        @(negedge clk);
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL %s_wb_pulse: got %0b want 0", nm, wb_en); end
    endtask

    task automatic test_load();
        do_load("load", 5'd4, 16'h0010, 3, 32'hCAFEBABE);
    endtask

    task automatic test_store();
        present(5'd9, 5'd7, 32'h0020, 32'hDEADBEEF, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL store_req: got req/we %02b want 11", {mem_req, mem_we}); end
        total++; if (mem_addr !== 16'h0020) begin bad++; $display("FAIL store_addr: got %h want 0020", mem_addr); end
        total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_wdata: got %h want deadbeef", mem_wdata); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if ({mem_req, wb_en} !== 2'b00) begin bad++; $display("FAIL store_done: got req/wb %02b want 00", {mem_req, wb_en}); end
        @(negedge clk);
        total++; if ({mem_req, wb_en, stall} !== 3'b000) begin bad++; $display("FAIL store_idle: got req/wb/stall %03b want 000", {mem_req, wb_en, stall}); end
    endtask

    task automatic test_error_flag();
        present(5'd8, 5'd5, 32'h0044, 32'h0, 5'b10000);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL err_stall: got %0b want 0", stall); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if ({mem_req, wb_en} !== 2'b00) begin bad++; $display("FAIL err_req_wb: got %02b want 00", {mem_req, wb_en}); end
        total++; if (wb_flags !== 5'b10000) begin bad++; $display("FAIL err_flags: got %05b want 10000", wb_flags); end
        @(negedge clk);
        total++; if ({mem_req, wb_flags} !== 6'b0) begin bad++; $display("FAIL err_after: got req=%0b flags=%05b want 0/00000", mem_req, wb_flags); end
    endtask

    task automatic test_rd0();
        do_load("rd0", 5'd0, 16'h0030, 1, 32'h00000055);
    endtask

    task automatic test_ack_ignored();
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if ({mem_req, wb_en, stall} !== 3'b000) begin bad++; $display("FAIL ack_idle: got req/wb/stall %03b want 000", {mem_req, wb_en, stall}); end
    endtask

    task automatic test_reset_mid_access();
        present(5'd8, 5'd6, 32'h0040, 32'h0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_before: got %0b want 1", mem_req); end
        rst = 1'b1;
        #1;
        total++; if ({mem_req, stall, wb_en} !== 3'b000) begin bad++; $display("FAIL rstmid_async: got req/stall/wb %03b want 000", {mem_req, stall, wb_en}); end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if ({mem_req, wb_en} !== 2'b00) begin bad++; $display("FAIL rstmid_abandon: got req/wb %02b want 00", {mem_req, wb_en}); end
        do_load("rstmid_reload", 5'd9, 16'h0050, 2, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back();
        present(5'd3, 5'd10, 32'hAAAA0001, 32'h0, 5'b00001);
        @(negedge clk);
        present(5'd0, 5'd11, 32'hBBBB0002, 32'h0, 5'b00010);
        total++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd10, 32'hAAAA0001}) begin bad++; $display("FAIL b2b_first: got %0b/%0d/%h want 1/10/aaaa0001", wb_en, wb_addr, wb_data); end
        @(negedge clk);
        present(5'd31, 5'd12, 32'hCCCC0003, 32'h0, 5'b01000);
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL b2b_nop: got %0b want 0", wb_en); end
        @(negedge clk);
        present(5'd4, 5'd0, 32'hDDDD0004, 32'h0, 5'b00000);
        total++; if ({wb_en, wb_addr, wb_data, wb_flags} !== {1'b1, 5'd12, 32'hCCCC0003, 5'b01000}) begin bad++; $display("FAIL b2b_second: got %0b/%0d/%h/%05b want 1/12/cccc0003/01000", wb_en, wb_addr, wb_data, wb_flags); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL b2b_alu_r0: got %0b want 0", wb_en); end
    endtask

    task automatic test_no_ack_wait();
        present(5'd8, 5'd2, 32'h0060, 32'h0, 5'd0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
            if (i <= 4) begin
                total++; if ({mem_req, mem_error} !== 2'b10) begin bad++; $display("FAIL to_wait_c%0d: got req/err %02b want 10", i, {mem_req, mem_error}); end
            end else if (i == 5) begin
                total++; if ({mem_req, mem_error, wb_en, stall} !== 4'b0100) begin bad++; $display("FAIL to_expire: got req/err/wb/stall %04b want 0100", {mem_req, mem_error, wb_en, stall}); end
            end else begin
                total++; if ({mem_req, mem_error, wb_en} !== 3'b000) begin bad++; $display("FAIL to_after: got req/err/wb %03b want 000", {mem_req, mem_error, wb_en}); end
            end
`else
            total++; if ({mem_req, mem_error, stall} !== 3'b101) begin bad++; $display("FAIL wait_c%0d: got req/err/stall %03b want 101", i, {mem_req, mem_error, stall}); end
`endif
        end
`ifndef MEM_TIMEOUT_EN
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if ({wb_en, wb_data} !== {1'b1, 32'h12345678}) begin bad++; $display("FAIL wait_late_ack: got %0b/%h want 1/12345678", wb_en, wb_data); end
        @(negedge clk);
`endif
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        stored_data = '0;
        stored_instr = '0;
        stored_register = '0;
        rflags = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_error_flag();
        test_rd0();
        test_ack_ignored();
        test_reset_mid_access();
        test_back_to_back();
        test_no_ack_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
